// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
// State, opcode and datapath select encodings plus the control vector.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11,
        S_BNE      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore decode of FSM state into the datapath control vector.
// BNE outputs exist only when MC_CTRL_BNE_EN is defined.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_ALU;
                // PC+4 and IR load only on the completing fetch cycle
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_RTYPE_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RTYPE_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src   = PC_JUMP;
                ctrl.pc_write = 1'b1;
            end
`ifdef MC_CTRL_BNE_EN
            S_BNE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_ALUOUT;
                ctrl.branch_ne = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Main control FSM and retired-instruction counter of the multi-cycle MIPS core.
// Optional bne support: define MC_CTRL_BNE_EN.
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int COUNT_W       = 32,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               branch,
    output logic               branch_ne,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_count,
    output logic [3:0]         state_dbg
);

    state_t state, state_n;
    ctrl_t  ctrl;
    logic   mrdy;
    logic   illegal;
    logic   retire;
    logic   zero_unused;

    // zero is consumed by the external PC-enable gate, not here
    assign zero_unused = zero;
    assign mrdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    always_comb begin
        state_n = state;
        illegal = 1'b0;
        unique case (state)
            S_FETCH:  if (mrdy) state_n = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    (op == OP_LW), (op == OP_SW): state_n = S_MEMADR;
                    (op == OP_RTYPE): state_n = S_RTYPE_EX;
                    (op == OP_BEQ):   state_n = S_BEQ;
                    (op == OP_ADDI):  state_n = S_ADDI_EX;
                    (op == OP_J):     state_n = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                    (op == OP_BNE):   state_n = S_BNE;
`endif
                    default: begin
                        state_n = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mrdy) state_n = S_MEMWB;
            S_MEMWR:    if (mrdy) state_n = S_FETCH;
            S_RTYPE_EX: state_n = S_RTYPE_WB;
            S_ADDI_EX:  state_n = S_ADDI_WB;
            default:    state_n = S_FETCH;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        unique case (state)
            S_MEMWB, S_RTYPE_WB, S_ADDI_WB,
            S_BEQ, S_JUMP: retire = 1'b1;
            S_MEMWR:       retire = mrdy;
`ifdef MC_CTRL_BNE_EN
            S_BNE:         retire = 1'b1;
`endif
            default:       retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            instr_count <= '0;
        end else begin
            state <= state_n;
            if (retire) instr_count <= instr_count + COUNT_W'(1);
        end
    end

    mc_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (mrdy),
        .ctrl      (ctrl)
    );

    // enables are forced low while reset is held
    assign pc_write   = ~reset & ctrl.pc_write;
    assign branch     = ~reset & ctrl.branch;
    assign branch_ne  = ~reset & ctrl.branch_ne;
    assign mem_read   = ~reset & ctrl.mem_read;
    assign mem_write  = ~reset & ctrl.mem_write;
    assign ir_write   = ~reset & ctrl.ir_write;
    assign reg_write  = ~reset & ctrl.reg_write;
    assign illegal_op = ~reset & illegal;

    assign iord       = ctrl.iord;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_dst    = ctrl.reg_dst;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_src     = ctrl.pc_src;
    assign state_dbg  = state;

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control.
// Walks add/lw/sw/beq/j/illegal/bne/reset sequences with hand-computed values.
module tb_mc_main_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, branch, branch_ne, iord, mem_read, mem_write;
    logic        ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic        illegal_op;
    logic [31:0] instr_count;
    logic [3:0]  state_dbg;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    mc_main_control dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .branch      (branch),
        .branch_ne   (branch_ne),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .pc_src      (pc_src),
        .illegal_op  (illegal_op),
        .instr_count (instr_count),
        .state_dbg   (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        settle();
        chk("rst_pc_write", pc_write, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_reg_write", reg_write, 0);
        tick();
        chk("rst_state", state_dbg, 0);
        chk("rst_count", instr_count, 0);
        reset = 1'b0;

        // add r3,r1,r2
        op = 6'b000000; mem_ready = 1'b1; settle();
        chk("add_f_state", state_dbg, 0);
        chk("add_f_mem_read", mem_read, 1);
        chk("add_f_ir_write", ir_write, 1);
        chk("add_f_pc_write", pc_write, 1);
        chk("add_f_srcb", alu_src_b, 2'b01);
        tick();
        chk("add_d_state", state_dbg, 1);
        chk("add_d_srcb", alu_src_b, 2'b11);
        chk("add_d_ir_write", ir_write, 0);
        tick();
        chk("add_ex_state", state_dbg, 6);
        chk("add_ex_aluop", alu_op, 2'b10);
        chk("add_ex_srca", alu_src_a, 1);
        chk("add_ex_reg_write", reg_write, 0);
        tick();
        chk("add_wb_state", state_dbg, 7);
        chk("add_wb_reg_write", reg_write, 1);
        chk("add_wb_reg_dst", reg_dst, 1);
        chk("add_wb_count", instr_count, 0);
        tick();
        exp_cnt++;
        chk("add_end_state", state_dbg, 0);
        chk("add_end_count", instr_count, exp_cnt);

        // lw with a stalled fetch and MEMRD stalled 3 cycles
        op = 6'b100011; mem_ready = 1'b0; settle();
        chk("lw_f_wait_ir", ir_write, 0);
        chk("lw_f_wait_pc", pc_write, 0);
        tick();
        chk("lw_f_hold", state_dbg, 0);
        mem_ready = 1'b1; settle();
        chk("lw_f_ir", ir_write, 1);
        tick();
        chk("lw_d_state", state_dbg, 1);
        tick();
        chk("lw_adr_state", state_dbg, 2);
        chk("lw_adr_srcb", alu_src_b, 2'b10);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("lw_rd_state", state_dbg, 3);
            chk("lw_rd_iord", iord, 1);
            chk("lw_rd_reg_write", reg_write, 0);
            tick();
        end
        mem_ready = 1'b1; settle();
        chk("lw_rd_last", state_dbg, 3);
        chk("lw_rd_mem_read", mem_read, 1);
        tick();
        chk("lw_wb_state", state_dbg, 4);
        chk("lw_wb_reg_write", reg_write, 1);
        chk("lw_wb_m2r", mem_to_reg, 1);
        chk("lw_wb_reg_dst", reg_dst, 0);
        tick();
        exp_cnt++;
        chk("lw_end_state", state_dbg, 0);
        chk("lw_end_reg_write", reg_write, 0);
        chk("lw_end_count", instr_count, exp_cnt);

        // sw with MEMWR stalled 2 cycles
        op = 6'b101011; tick(); tick(); tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("sw_wr_state", state_dbg, 5);
            chk("sw_wr_mem_write", mem_write, 1);
            chk("sw_wr_iord", iord, 1);
            chk("sw_wr_reg_write", reg_write, 0);
            tick();
        end
        mem_ready = 1'b1; settle();
        chk("sw_wr_last", mem_write, 1);
        chk("sw_wr_count", instr_count, exp_cnt);
        tick();
        exp_cnt++;
        chk("sw_end_state", state_dbg, 0);
        chk("sw_end_mem_write", mem_write, 0);
        chk("sw_end_count", instr_count, exp_cnt);

        // beq then j
        op = 6'b000100; tick(); tick();
        chk("beq_state", state_dbg, 8);
        chk("beq_branch", branch, 1);
        chk("beq_pc_src", pc_src, 2'b01);
        chk("beq_aluop", alu_op, 2'b01);
        chk("beq_pc_write", pc_write, 0);
        tick();
        op = 6'b000010; tick(); tick();
        chk("j_state", state_dbg, 11);
        chk("j_pc_write", pc_write, 1);
        chk("j_pc_src", pc_src, 2'b10);
        chk("j_branch", branch, 0);
        tick();
        exp_cnt += 2;
        chk("bj_count", instr_count, exp_cnt);

        // unsupported opcode
        op = 6'b111111; tick();
        chk("ill_d_state", state_dbg, 1);
        chk("ill_pulse", illegal_op, 1);
        tick();
        chk("ill_ret_state", state_dbg, 0);
        chk("ill_clear", illegal_op, 0);
        chk("ill_count", instr_count, exp_cnt);

        // bne: legal only with the feature macro
        op = 6'b000101; tick();
`ifdef MC_CTRL_BNE_EN
        chk("bne_no_ill", illegal_op, 0);
        tick();
        chk("bne_state", state_dbg, 12);
        chk("bne_branch_ne", branch_ne, 1);
        chk("bne_pc_src", pc_src, 2'b01);
        tick();
        exp_cnt++;
`else
        chk("bne_ill", illegal_op, 1);
        chk("bne_branch_ne", branch_ne, 0);
        tick();
`endif
        chk("bne_ret_state", state_dbg, 0);
        chk("bne_count", instr_count, exp_cnt);

        // reset during RTYPE_EX
        op = 6'b000000; tick(); tick();
        chk("rex_state", state_dbg, 6);
        reset = 1'b1; settle();
        chk("rex_rst_reg_write", reg_write, 0);
        chk("rex_rst_pc_write", pc_write, 0);
        tick();
        chk("rex_rst_state", state_dbg, 0);
        chk("rex_rst_count", instr_count, 0);
        chk("rex_rst_mem_read", mem_read, 0);
        chk("rex_rst_ir_write", ir_write, 0);
        chk("rex_rst_pc_write2", pc_write, 0);
        chk("rex_no_reg_write", reg_write, 0);
        tick();
        chk("rex_rst_hold", state_dbg, 0);
        reset = 1'b0; settle();
        chk("rex_rel_mem_read", mem_read, 1);
        tick();
        chk("rex_rel_state", state_dbg, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
